// File: rtl/score_glyph_fetcher.sv
// Two-digit BCD score with per-frame display shadow and a two-stage glyph fetch pipeline.
// Build option: define SCORE_BLANK_LEADING_ZERO_EN to suppress drawing a leading tens zero.
module score_glyph_fetcher #(
    parameter int GLYPH_W    = 11,
    parameter int GLYPH_H    = 16,
    parameter int SCALE_LOG2 = 1,
    parameter int X0         = 280,
    parameter int Y0         = 16,
    parameter int GAP        = 4,
    parameter int MAX_SCORE  = 99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       pixel_valid,
    input  logic [9:0] pixel_row,
    input  logic [9:0] pixel_col,
    input  logic       score_inc,
    input  logic       score_clr,
    output logic [3:0] glyph_digit,
    output logic [9:0] glyph_row,
    output logic [9:0] glyph_col,
    input  logic [2:0] glyph_rgb,
    output logic [2:0] rgb_out,
    output logic       rgb_valid,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones,
    output logic       score_max
);

    localparam logic [10:0] BW    = 11'(GLYPH_W << SCALE_LOG2);
    localparam logic [10:0] BH    = 11'(GLYPH_H << SCALE_LOG2);
    localparam logic [10:0] X0_W  = 11'(X0);
    localparam logic [10:0] X1_W  = 11'(X0 + (GLYPH_W << SCALE_LOG2) + GAP);
    localparam logic [10:0] Y0_W  = 11'(Y0);
    localparam logic [3:0]  MAX_T = 4'(MAX_SCORE / 10);
    localparam logic [3:0]  MAX_O = 4'(MAX_SCORE % 10);

    logic [3:0] tens_q, tens_d, ones_q, ones_d;
    logic [3:0] disp_tens_q, disp_ones_q;
    logic [3:0] digit_q, digit_d;
    logic [9:0] row_q, row_d, col_q, col_d;
    logic       hit1_q, valid1_q;
    logic [2:0] rgb_q;
    logic       rgb_valid_q;

    logic        at_max;
    logic [10:0] row_w, col_w, row_off, col_off;
    logic        in_rows, in_tens, in_ones, tens_hit, hit;
    logic [3:0]  shadow_tens, shadow_ones;

    assign at_max = (tens_q == MAX_T) && (ones_q == MAX_O);

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (score_clr) begin
            tens_d = 4'd0;
            ones_d = 4'd0;
        end else if (score_inc && !at_max) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    // A pixel sampled together with frame_start already sees the newly latched digits.
    assign shadow_tens = frame_start ? tens_q : disp_tens_q;
    assign shadow_ones = frame_start ? ones_q : disp_ones_q;

    assign row_w   = {1'b0, pixel_row};
    assign col_w   = {1'b0, pixel_col};
    assign in_rows = (row_w >= Y0_W) && (row_w < Y0_W + BH);
    assign in_tens = in_rows && (col_w >= X0_W) && (col_w < X0_W + BW);
    assign in_ones = in_rows && (col_w >= X1_W) && (col_w < X1_W + BW);

`ifdef SCORE_BLANK_LEADING_ZERO_EN
    assign tens_hit = in_tens && (shadow_tens != 4'd0);
`else
    assign tens_hit = in_tens;
`endif

    assign hit     = pixel_valid && (tens_hit || in_ones);
    assign row_off = row_w - Y0_W;
    assign col_off = col_w - (tens_hit ? X0_W : X1_W);

    always_comb begin
        digit_d = 4'd0;
        row_d   = 10'h3FF;
        col_d   = 10'h3FF;
        if (hit) begin
            digit_d = tens_hit ? shadow_tens : shadow_ones;
            row_d   = 10'(row_off >> SCALE_LOG2);
            col_d   = 10'(col_off >> SCALE_LOG2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q      <= 4'd0;
            ones_q      <= 4'd0;
            disp_tens_q <= 4'd0;
            disp_ones_q <= 4'd0;
            digit_q     <= 4'd0;
            row_q       <= 10'd0;
            col_q       <= 10'd0;
            hit1_q      <= 1'b0;
            valid1_q    <= 1'b0;
            rgb_q       <= 3'd0;
            rgb_valid_q <= 1'b0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
            if (frame_start) begin
                disp_tens_q <= tens_q;
                disp_ones_q <= ones_q;
            end
            digit_q     <= digit_d;
            row_q       <= row_d;
            col_q       <= col_d;
            hit1_q      <= hit;
            valid1_q    <= pixel_valid;
            rgb_q       <= (valid1_q && hit1_q) ? glyph_rgb : 3'd0;
            rgb_valid_q <= valid1_q;
        end
    end

    assign glyph_digit = digit_q;
    assign glyph_row   = row_q;
    assign glyph_col   = col_q;
    assign rgb_out     = rgb_q;
    assign rgb_valid   = rgb_valid_q;
    assign score_tens  = tens_q;
    assign score_ones  = ones_q;
    assign score_max   = at_max;

endmodule

// File: tb/tb_score_glyph_fetcher.sv
// Directed bench for score_glyph_fetcher: table of pixel vectors plus score/frame/reset sequences.
module tb_score_glyph_fetcher;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       pixel_valid = 1'b0;
    logic [9:0] pixel_row = 10'd0;
    logic [9:0] pixel_col = 10'd0;
    logic       score_inc = 1'b0;
    logic       score_clr = 1'b0;
    logic [3:0] glyph_digit;
    logic [9:0] glyph_row, glyph_col;
    logic [2:0] glyph_rgb;
    logic [2:0] rgb_out;
    logic       rgb_valid;
    logic [3:0] score_tens, score_ones;
    logic       score_max;

    int n_checks = 0;
    int n_fail   = 0;

    score_glyph_fetcher dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pixel_valid(pixel_valid),
        .pixel_row(pixel_row), .pixel_col(pixel_col), .score_inc(score_inc), .score_clr(score_clr),
        .glyph_digit(glyph_digit), .glyph_row(glyph_row), .glyph_col(glyph_col),
        .glyph_rgb(glyph_rgb), .rgb_out(rgb_out), .rgb_valid(rgb_valid),
        .score_tens(score_tens), .score_ones(score_ones), .score_max(score_max)
    );

    always #5 clk = ~clk;

    // Stand-in glyph ROM: nonzero everywhere inside the 11x16 glyph, 000 outside.
    function automatic logic [2:0] rom(input logic [3:0] d, input logic [9:0] r, input logic [9:0] c);
        if (r >= 10'd16 || c >= 10'd11) return 3'd0;
        return 3'((int'(d) * 5 + int'(r) * 3 + int'(c)) % 7 + 1);
    endfunction

    always_comb glyph_rgb = rom(glyph_digit, glyph_row, glyph_col);

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_inc(input int n);
        score_inc = 1'b1;
        repeat (n) @(negedge clk);
        score_inc = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    typedef struct {
        logic       v;
        logic [9:0] r;
        logic [9:0] c;
        logic [3:0] ed;
        logic [9:0] er;
        logic [9:0] ec;
    } vec_t;

    vec_t tbl[10];

    task automatic run_vec(input vec_t t, input int idx);
        logic [2:0] exp_rgb;
        pixel_valid = t.v;
        pixel_row   = t.r;
        pixel_col   = t.c;
        @(negedge clk);
        chk($sformatf("vec%0d digit", idx), int'(glyph_digit), int'(t.ed));
        chk($sformatf("vec%0d row", idx), int'(glyph_row), int'(t.er));
        chk($sformatf("vec%0d col", idx), int'(glyph_col), int'(t.ec));
        pixel_valid = 1'b0;
        @(negedge clk);
        exp_rgb = (t.v && t.er != 10'h3FF) ? rom(t.ed, t.er, t.ec) : 3'd0;
        chk($sformatf("vec%0d rgb_valid", idx), int'(rgb_valid), int'(t.v));
        chk($sformatf("vec%0d rgb_out", idx), int'(rgb_out), int'(exp_rgb));
    endtask

    initial begin
        // display 13: tens box cols 280..301, ones box cols 306..327, rows 16..47
        tbl[0] = '{1'b1, 10'd16, 10'd306, 4'd3, 10'd0,    10'd0};
        tbl[1] = '{1'b1, 10'd47, 10'd301, 4'd1, 10'd15,   10'd10};
        tbl[2] = '{1'b1, 10'd16, 10'd303, 4'd0, 10'h3FF,  10'h3FF};
        tbl[3] = '{1'b1, 10'd48, 10'd290, 4'd0, 10'h3FF,  10'h3FF};
        tbl[4] = '{1'b0, 10'd20, 10'd285, 4'd0, 10'h3FF,  10'h3FF};
        tbl[5] = '{1'b1, 10'd16, 10'd280, 4'd1, 10'd0,    10'd0};
        tbl[6] = '{1'b1, 10'd16, 10'd327, 4'd3, 10'd0,    10'd10};
        tbl[7] = '{1'b1, 10'd15, 10'd306, 4'd0, 10'h3FF,  10'h3FF};
        tbl[8] = '{1'b1, 10'd16, 10'd328, 4'd0, 10'h3FF,  10'h3FF};
        tbl[9] = '{1'b1, 10'd16, 10'd302, 4'd0, 10'h3FF,  10'h3FF};

        #2;
        chk("rst rgb_out", int'(rgb_out), 0);
        chk("rst rgb_valid", int'(rgb_valid), 0);
        chk("rst glyph_row", int'(glyph_row), 0);
        chk("rst glyph_col", int'(glyph_col), 0);
        chk("rst score", int'({score_tens, score_ones}), 0);
        chk("rst score_max", int'(score_max), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        pulse_inc(13);
        chk("inc13 tens", int'(score_tens), 1);
        chk("inc13 ones", int'(score_ones), 3);
        pulse_frame();
        for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

        // asynchronous reset while a lit pixel sits in the output register
        pixel_valid = 1'b1; pixel_row = 10'd47; pixel_col = 10'd301;
        repeat (2) @(negedge clk);
        chk("pre-rst rgb_out", int'(rgb_out), 5);
        #2 rst_n = 1'b0;
        #1;
        chk("async rgb_out", int'(rgb_out), 0);
        chk("async rgb_valid", int'(rgb_valid), 0);
        chk("async digit", int'(glyph_digit), 0);
        chk("async row", int'(glyph_row), 0);
        chk("async col", int'(glyph_col), 0);
        chk("async score", int'({score_tens, score_ones}), 0);
        pixel_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pixel_valid = 1'b1; pixel_row = 10'd16; pixel_col = 10'd306;
        @(negedge clk);
        chk("post-rst rgb_valid 1cyc", int'(rgb_valid), 0);
        chk("post-rst digit", int'(glyph_digit), 0);
        pixel_valid = 1'b0;
        @(negedge clk);
        chk("post-rst rgb_valid 2cyc", int'(rgb_valid), 1);
        chk("post-rst rgb_out", int'(rgb_out), int'(rom(4'd0, 10'd0, 10'd0)));

        // leading zero tens box, score 07
        pulse_inc(7);
        pulse_frame();
`ifdef SCORE_BLANK_LEADING_ZERO_EN
        run_vec('{1'b1, 10'd20, 10'd285, 4'd0, 10'h3FF, 10'h3FF}, 20);
`else
        run_vec('{1'b1, 10'd20, 10'd285, 4'd0, 10'd2, 10'd2}, 20);
`endif
        // frame_start coincides with the pixel: new shadow (08) used immediately
        pulse_inc(1);
        frame_start = 1'b1;
        pixel_valid = 1'b1; pixel_row = 10'd16; pixel_col = 10'd306;
        @(negedge clk);
        frame_start = 1'b0; pixel_valid = 1'b0;
        chk("coincide digit", int'(glyph_digit), 8);
        @(negedge clk);

        // mid-frame update must not reach the display until the next frame
        score_clr = 1'b1;
        @(negedge clk);
        score_clr = 1'b0;
        pulse_inc(12);
        pulse_frame();
        pixel_valid = 1'b1; pixel_row = 10'd16; pixel_col = 10'd306;
        score_inc = 1'b1;
        @(negedge clk);
        score_inc = 1'b0;
        chk("midframe digit", int'(glyph_digit), 2);
        chk("midframe live ones", int'(score_ones), 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midframe hold digit", int'(glyph_digit), 2);
        end
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("newframe digit", int'(glyph_digit), 3);
        pixel_valid = 1'b0;
        @(negedge clk);

        // saturation and clear priority
        score_clr = 1'b1;
        @(negedge clk);
        score_clr = 1'b0;
        pulse_inc(105);
        chk("sat tens", int'(score_tens), 9);
        chk("sat ones", int'(score_ones), 9);
        chk("sat max", int'(score_max), 1);
        score_inc = 1'b1; score_clr = 1'b1;
        @(negedge clk);
        score_inc = 1'b0; score_clr = 1'b0;
        chk("clr prio score", int'({score_tens, score_ones}), 0);
        chk("clr prio max", int'(score_max), 0);

        // shadow latches the value from before the frame_start edge
        frame_start = 1'b1; score_inc = 1'b1;
        @(negedge clk);
        frame_start = 1'b0; score_inc = 1'b0;
        chk("same-cycle inc live", int'(score_ones), 1);
        pixel_valid = 1'b1; pixel_row = 10'd16; pixel_col = 10'd306;
        @(negedge clk);
        pixel_valid = 1'b0;
        chk("same-cycle inc shadow", int'(glyph_digit), 0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/score_glyph_fetcher.md
# score_glyph_fetcher

Two-digit score counter and glyph-fetch front end for the Pong score display. It keeps one player's decimal score and maps each VGA pixel coordinate onto the local row/column of the digit glyph it falls in. It drives those coordinates to the combinational digit-glyph ROM mux (11x16, 3-bit rgb, row-major, rgb=000 outside the glyph) and registers the returned pixel into the video path with fixed latency.

## Interface
- GLYPH_W, 11, glyph width in pixels
- GLYPH_H, 16, glyph height in pixels
- SCALE_LOG2, 1, on-screen magnification = 2^SCALE_LOG2 (0..3)
- X0, 280, screen column of the tens-digit box's left edge
- Y0, 16, screen row of both digit boxes' top edge
- GAP, 4, blank columns between tens box and ones box
- MAX_SCORE, 99, saturation value (1..99)
- clk  in  1  pixel clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at start of each frame
- pixel_valid  in  1  pixel_row/pixel_col are in the visible area
- pixel_row  in  10  current screen row
- pixel_col  in  10  current screen column
- score_inc  in  1  one-cycle pulse: add one point
- score_clr  in  1  one-cycle pulse: score to 00
- glyph_digit  out  4  digit (0..9) selecting the glyph ROM
- glyph_row  out  10  glyph-local row to ROM
- glyph_col  out  10  glyph-local column to ROM
- glyph_rgb  in  3  combinational ROM data for glyph_digit/row/col
- rgb_out  out  3  registered pixel colour
- rgb_valid  out  1  rgb_out corresponds to a valid pixel
- score_tens  out  4  live tens digit (BCD)
- score_ones  out  4  live ones digit (BCD)
- score_max  out  1  live score == MAX_SCORE

## Operation
- Score register: BCD pair {tens, ones}.
  - score_clr has priority over score_inc; with both high, the result is 00.
  - score_inc below MAX_SCORE: ones+1; ones 9 wraps to 0 with tens+1.
  - score_inc at MAX_SCORE: no change, score_max stays 1.
  - score_max is combinational from the register.
- Display shadow {disp_tens, disp_ones} loads the score register value present before the frame_start edge; an inc/clr in the same cycle appears next frame. The shadow changes only on frame_start, so no mid-frame tearing.
- Box geometry, with BW = GLYPH_W<<SCALE_LOG2 and BH = GLYPH_H<<SCALE_LOG2:
  - tens box: cols [X0, X0+BW), rows [Y0, Y0+BH).
  - ones box: cols [X0+BW+GAP, X0+2*BW+GAP), same rows.
  - Compares use 11-bit unsigned arithmetic; no wrap.
- Stage 1 (registered):
  - hit1 = pixel_valid and pixel inside a box.
  - glyph_digit = disp digit of that box.
  - glyph_row = (pixel_row-Y0)>>SCALE_LOG2; glyph_col = (pixel_col-boxX)>>SCALE_LOG2.
  - On a miss, glyph_row/glyph_col = 10'h3FF and glyph_digit = 0, so the ROM returns 000.
  - valid1 = pixel_valid.
- Stage 2 (registered): rgb_out = (valid1 & hit1) ? glyph_rgb : 000; rgb_valid = valid1.

## Timing
- Reset: rgb_out=000, rgb_valid=0, glyph_digit=0, glyph_row=0, glyph_col=0, score 00, shadow 00, score_max=0 (for MAX_SCORE>0). Takes effect immediately on rst_n low, mid-frame included. Pipeline contents are discarded.
- Latency: pixel inputs sampled at edge N; ROM address valid after N; rgb_out/rgb_valid valid after N+1 (2 cycles). Throughput is one pixel per clock, no stalls.
- Score outputs update on the edge sampling the pulse. Pulses held high count once per cycle high.
- frame_start and pixel_valid may coincide; the pixel sampled that cycle already uses the new shadow.

## Configuration
- SCORE_BLANK_LEADING_ZERO_EN defined: when disp_tens==0, tens-box pixels are treated as misses. The result is rgb_out=000 and glyph address 3FF.
- Not defined: tens digit 0 is drawn normally.

## Test plan
- Reset mid-stream: rst_n low while rgb_out=101 -> all outputs 0 without a clock edge. After release, the score is 00 and first rgb_valid appears 2 cycles after pixel_valid.
- 13 score_inc pulses, frame_start, pixel (row 16, col 306) -> glyph_digit=3, row 0, col 0 one cycle later. Pixel (row 47, col 301) -> digit 1, row 15, col 10. rgb_out equals the supplied glyph_rgb 2 cycles after each pixel.
- 105 score_inc pulses -> tens=9, ones=9, score_max=1. Then score_inc+score_clr in the same cycle -> 00, score_max=0.
- Mid-frame update: display 12; score_inc while pixels stream -> glyph_digit stays 2 until the next frame_start, then 3.
- Misses: pixel (row 16, col 303) gap, (row 48, col 290), or pixel_valid=0 -> rgb_out=000. rgb_valid follows pixel_valid. glyph_row/col=3FF on pixel misses.
- Score 07, pixel (row 20, col 285): with macro -> rgb_out=000; without -> glyph_digit=0, glyph_row=2, glyph_col=2.
